// File: rtl/alu_issue_ctrl.sv
// Issue controller: 8x16 register file, operand issue to an external ALU, writeback and flags.
// Optional macro ISSUE_TIMEOUT_EN aborts a WAIT that lasts TIMEOUT_CYC cycles without alu_done.
module alu_issue_ctrl #(
   parameter int TIMEOUT_CYC = 63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   input  logic        ld_en,
   input  logic [2:0]  ld_addr,
   input  logic [15:0] ld_data,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_opcode,
   input  logic [31:0] alu_result,
   input  logic        alu_done,
   output logic        busy,
   output logic        carry_flag,
   output logic        illegal_op,
   output logic        timeout_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_WB    = 2'd3;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_NONE = 3'b111;

   logic [1:0]  state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [2:0]  rd_q, rd_d;
   logic [2:0]  rs1_q, rs1_d;
   logic [2:0]  rs2_q, rs2_d;
   logic [15:0] alu_a_q, alu_a_d;
   logic [15:0] alu_b_q, alu_b_d;
   logic [2:0]  alu_op_q, alu_op_d;
   logic [31:0] res_q, res_d;
   logic        carry_q, carry_d;
   logic        illegal_q, illegal_d;
   logic [15:0] rf_q [8];
   logic [15:0] rf_d [8];
   logic        timeout_hit;
   logic        unused_instr_bits;

   assign unused_instr_bits = ^instr[3:0];

`ifdef ISSUE_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   logic [CW-1:0] wait_cnt_q;
   logic          timeout_q;

   // Counter holds the number of WAIT cycles already completed.
   assign timeout_hit = (state_q == S_WAIT) && !alu_done && (wait_cnt_q == CW'(TIMEOUT_CYC - 1));
   assign timeout_err = timeout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
         if (timeout_hit) timeout_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path infers a latch.
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      res_d     = res_q;
      carry_d   = carry_q;
      illegal_d = illegal_q;
      rf_d      = rf_q;

      // Load goes first so a same-cycle writeback to the same register overrides it.
      if (ld_en) rf_d[ld_addr] = ld_data;

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               if (instr[15:13] == OP_ADD || instr[15:13] == OP_SUB || instr[15:13] == OP_MUL) begin
                  op_d    = instr[15:13];
                  rd_d    = instr[12:10];
                  rs1_d   = instr[9:7];
                  rs2_d   = instr[6:4];
                  state_d = S_ISSUE;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            alu_a_d  = rf_q[rs1_q];
            alu_b_d  = rf_q[rs2_q];
            alu_op_d = op_q;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (alu_done) begin
               res_d   = alu_result;
               state_d = S_WB;
            end else if (timeout_hit) begin
               alu_op_d = OP_NONE;
               state_d  = S_IDLE;
            end
         end
         default: begin
            rf_d[rd_q] = res_q[15:0];
            if (op_q == OP_MUL && rd_q != 3'd7) rf_d[rd_q + 3'd1] = res_q[31:16];
            if (op_q == OP_ADD) carry_d = res_q[16];
            if (op_q == OP_SUB) carry_d = res_q[31];
            alu_op_d = OP_NONE;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= OP_ADD;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= OP_NONE;
         res_q     <= '0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
         // NOTE: the register file must read 0 after reset, so it is flops with reset, not RAM.
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         res_q     <= res_d;
         carry_q   <= carry_d;
         illegal_q <= illegal_d;
         for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign dbg_data    = rf_q[dbg_addr];
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_opcode  = alu_op_q;
   assign carry_flag  = carry_q;
   assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl; the bench plays the external ALU.
// Build with ISSUE_TIMEOUT_EN defined to exercise the timeout abort instead of the long wait.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_opcode;
   logic [31:0] alu_result;
   logic        alu_done;
   logic        busy;
   logic        carry_flag;
   logic        illegal_op;
   logic        timeout_err;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [15:0] exp_rf [8];

   alu_issue_ctrl #(.TIMEOUT_CYC(63)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_a(alu_a), .alu_b(alu_b),
      .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_done(alu_done),
      .busy(busy), .carry_flag(carry_flag), .illegal_op(illegal_op), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Behavioural ALU driven from the DUT's operand outputs.
   function automatic logic [31:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
      case (op)
         3'b000:  return {15'd0, {1'b0, a} + {1'b0, b}};
         3'b001:  return {16'd0, a} - {16'd0, b};
         3'b010:  return {16'd0, a} * {16'd0, b};
         default: return 32'd0;
      endcase
   endfunction

   task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
      dbg_addr = a;
      #1;
      v = dbg_data;
   endtask

   task automatic load(input logic [2:0] a, input logic [15:0] v);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = v;
      @(negedge clk);
      ld_en = 1'b0;
      exp_rf[a] = v;
   endtask

   // ld_phase: 0 none, 1 load with accept, 2 load during ISSUE, 3 load during WB.
   task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                            input logic [2:0] rs2, input int delay, input int ld_phase,
                            input logic [2:0] la, input logic [15:0] lv, output int lat);
      @(negedge clk);
      instr_valid = 1'b1; instr = {op, rd, rs1, rs2, 4'h0};
      if (ld_phase == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
      @(negedge clk);
      instr_valid = 1'b0; ld_en = 1'b0; lat = 1;
      if (ld_phase == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
      @(negedge clk);
      ld_en = 1'b0; lat = 2;
      repeat (delay) begin @(negedge clk); lat++; end
      alu_result = alu_model(alu_a, alu_b, alu_opcode);
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0; lat++;
      if (ld_phase == 3) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
      @(negedge clk);
      ld_en = 1'b0; lat++;
      while (!instr_ready && lat < 200) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset();
      logic [15:0] v;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_chk++; if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", instr_ready); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
      n_chk++; if (alu_opcode !== 3'b111) $display("FAIL reset_opcode: got %b exp 111", alu_opcode); else n_pass++;
      n_chk++; if ({alu_a, alu_b} !== 32'd0) $display("FAIL reset_operands: got %h exp 0", {alu_a, alu_b}); else n_pass++;
      n_chk++; if ({carry_flag, illegal_op, timeout_err} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {carry_flag, illegal_op, timeout_err}); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         exp_rf[i] = 16'h0000;
         read_reg(3'(i), v);
         n_chk++; if (v !== 16'h0000) $display("FAIL reset_R%0d: got %h exp 0000", i, v); else n_pass++;
      end
   endtask

   task automatic test_add();
      int lat;
      logic [15:0] v;
      load(3'd1, 16'hFFFF);
      load(3'd2, 16'h0001);
      read_reg(3'd1, v);
      n_chk++; if (v !== 16'hFFFF) $display("FAIL add_dbg_load: got %h exp FFFF", v); else n_pass++;
      run_instr(3'b000, 3'd3, 3'd1, 3'd2, 0, 0, 3'd0, 16'h0, lat);
      exp_rf[3] = 16'h0000;
      read_reg(3'd3, v);
      n_chk++; if (v !== 16'h0000) $display("FAIL add_R3: got %h exp 0000", v); else n_pass++;
      n_chk++; if (carry_flag !== 1'b1) $display("FAIL add_carry: got %b exp 1", carry_flag); else n_pass++;
      n_chk++; if (lat !== 4) $display("FAIL add_latency: got %0d exp 4", lat); else n_pass++;
      n_chk++; if (alu_opcode !== 3'b111) $display("FAIL add_idle_opcode: got %b exp 111", alu_opcode); else n_pass++;
   endtask

   task automatic test_mul();
      int lat;
      logic [15:0] v;
      load(3'd0, 16'hAAAA);
      load(3'd1, 16'h1234);
      load(3'd2, 16'h5678);
      run_instr(3'b010, 3'd5, 3'd1, 3'd2, 10, 0, 3'd0, 16'h0, lat);
      read_reg(3'd5, v);
      n_chk++; if (v !== 16'h0060) $display("FAIL mul_R5: got %h exp 0060", v); else n_pass++;
      read_reg(3'd6, v);
      n_chk++; if (v !== 16'h0626) $display("FAIL mul_R6: got %h exp 0626", v); else n_pass++;
      n_chk++; if (lat !== 14) $display("FAIL mul_latency: got %0d exp 14", lat); else n_pass++;
      n_chk++; if (carry_flag !== 1'b1) $display("FAIL mul_carry_kept: got %b exp 1", carry_flag); else n_pass++;
      run_instr(3'b010, 3'd7, 3'd1, 3'd2, 2, 0, 3'd0, 16'h0, lat);
      read_reg(3'd7, v);
      n_chk++; if (v !== 16'h0060) $display("FAIL mul_R7: got %h exp 0060", v); else n_pass++;
      read_reg(3'd0, v);
      n_chk++; if (v !== 16'hAAAA) $display("FAIL mul_R0_nowrap: got %h exp AAAA", v); else n_pass++;
      exp_rf[5] = 16'h0060; exp_rf[6] = 16'h0626; exp_rf[7] = 16'h0060;
   endtask

   task automatic test_sub();
      int lat;
      logic [15:0] v;
      load(3'd1, 16'h0005);
      load(3'd2, 16'h0007);
      run_instr(3'b001, 3'd4, 3'd1, 3'd2, 1, 0, 3'd0, 16'h0, lat);
      read_reg(3'd4, v);
      n_chk++; if (v !== 16'hFFFE) $display("FAIL sub_neg_R4: got %h exp FFFE", v); else n_pass++;
      n_chk++; if (carry_flag !== 1'b1) $display("FAIL sub_neg_borrow: got %b exp 1", carry_flag); else n_pass++;
      load(3'd1, 16'h0007);
      load(3'd2, 16'h0005);
      run_instr(3'b001, 3'd4, 3'd1, 3'd2, 0, 0, 3'd0, 16'h0, lat);
      read_reg(3'd4, v);
      n_chk++; if (v !== 16'h0002) $display("FAIL sub_pos_R4: got %h exp 0002", v); else n_pass++;
      n_chk++; if (carry_flag !== 1'b0) $display("FAIL sub_pos_borrow: got %b exp 0", carry_flag); else n_pass++;
      n_chk++; if (lat !== 4) $display("FAIL sub_latency: got %0d exp 4", lat); else n_pass++;
      exp_rf[4] = 16'h0002;
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [15:0] v;
      run_instr(3'b000, 3'd1, 3'd5, 3'd6, 0, 0, 3'd0, 16'h0, lat);
      run_instr(3'b000, 3'd2, 3'd1, 3'd1, 0, 0, 3'd0, 16'h0, lat);
      read_reg(3'd1, v);
      n_chk++; if (v !== 16'h0686) $display("FAIL b2b_R1: got %h exp 0686", v); else n_pass++;
      read_reg(3'd2, v);
      n_chk++; if (v !== 16'h0D0C) $display("FAIL b2b_R2: got %h exp 0D0C", v); else n_pass++;
      exp_rf[1] = 16'h0686; exp_rf[2] = 16'h0D0C;
   endtask

   task automatic test_load_collisions();
      int lat;
      logic [15:0] v;
      run_instr(3'b000, 3'd3, 3'd1, 3'd2, 0, 2, 3'd1, 16'h1111, lat);
      read_reg(3'd3, v);
      n_chk++; if (v !== 16'h1392) $display("FAIL ld_issue_old_operand: got %h exp 1392", v); else n_pass++;
      read_reg(3'd1, v);
      n_chk++; if (v !== 16'h1111) $display("FAIL ld_issue_written: got %h exp 1111", v); else n_pass++;
      run_instr(3'b000, 3'd3, 3'd3, 3'd1, 0, 3, 3'd3, 16'hBEEF, lat);
      read_reg(3'd3, v);
      n_chk++; if (v !== 16'h24A3) $display("FAIL ld_wb_wb_wins: got %h exp 24A3", v); else n_pass++;
      run_instr(3'b000, 3'd4, 3'd7, 3'd7, 0, 1, 3'd7, 16'h0007, lat);
      read_reg(3'd7, v);
      n_chk++; if (v !== 16'h0007) $display("FAIL ld_accept_written: got %h exp 0007", v); else n_pass++;
      read_reg(3'd4, v);
      n_chk++; if (v !== 16'h000E) $display("FAIL ld_accept_result: got %h exp 000E", v); else n_pass++;
      exp_rf[1] = 16'h1111; exp_rf[3] = 16'h24A3; exp_rf[4] = 16'h000E; exp_rf[7] = 16'h0007;
   endtask

   task automatic test_illegal();
      logic [15:0] v;
      @(negedge clk);
      instr_valid = 1'b1; instr = {3'b101, 3'd0, 3'd1, 3'd2, 4'h0};
      @(negedge clk);
      instr_valid = 1'b0;
      n_chk++; if (illegal_op !== 1'b1) $display("FAIL illegal_flag: got %b exp 1", illegal_op); else n_pass++;
      n_chk++; if (instr_ready !== 1'b1) $display("FAIL illegal_ready: got %b exp 1", instr_ready); else n_pass++;
      repeat (3) @(negedge clk);
      n_chk++; if ({instr_ready, busy, illegal_op} !== 3'b101) $display("FAIL illegal_idle_sticky: got %b exp 101", {instr_ready, busy, illegal_op}); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), v);
         n_chk++; if (v !== exp_rf[i]) $display("FAIL illegal_R%0d: got %h exp %h", i, v, exp_rf[i]); else n_pass++;
      end
   endtask

   task automatic test_wait_limit();
      logic [15:0] v;
`ifdef ISSUE_TIMEOUT_EN
      int wait_cyc;
      int guard;
      @(negedge clk);
      instr_valid = 1'b1; instr = {3'b000, 3'd3, 3'd1, 3'd2, 4'h0};
      @(negedge clk);
      instr_valid = 1'b0;
      wait_cyc = 0;
      guard = 0;
      while (busy && guard < 200) begin
         if (alu_opcode != 3'b111) wait_cyc++;
         @(negedge clk);
         guard++;
      end
      n_chk++; if (wait_cyc !== 63) $display("FAIL timeout_wait_cycles: got %0d exp 63", wait_cyc); else n_pass++;
      n_chk++; if ({timeout_err, instr_ready} !== 2'b11) $display("FAIL timeout_flag_ready: got %b exp 11", {timeout_err, instr_ready}); else n_pass++;
      read_reg(3'd3, v);
      n_chk++; if (v !== 16'h24A3) $display("FAIL timeout_no_wb: got %h exp 24A3", v); else n_pass++;
`else
      int lat;
      run_instr(3'b001, 3'd5, 3'd1, 3'd2, 100, 0, 3'd0, 16'h0, lat);
      n_chk++; if (timeout_err !== 1'b0) $display("FAIL long_wait_timeout_err: got %b exp 0", timeout_err); else n_pass++;
      read_reg(3'd5, v);
      n_chk++; if (v !== 16'h0405) $display("FAIL long_wait_R5: got %h exp 0405", v); else n_pass++;
      n_chk++; if (lat !== 104) $display("FAIL long_wait_latency: got %0d exp 104", lat); else n_pass++;
      exp_rf[5] = 16'h0405;
`endif
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] v;
      @(negedge clk);
      instr_valid = 1'b1; instr = {3'b010, 3'd5, 3'd1, 3'd2, 4'h0};
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (busy !== 1'b1) $display("FAIL midop_busy_before: got %b exp 1", busy); else n_pass++;
      alu_result = 32'hDEAD_BEEF;
      #2 reset = 1'b1;
      #1;
      n_chk++; if ({instr_ready, busy} !== 2'b10) $display("FAIL midop_async_ready: got %b exp 10", {instr_ready, busy}); else n_pass++;
      @(negedge clk);
      alu_done = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      alu_done = 1'b0;
      @(negedge clk);
      n_chk++; if (alu_opcode !== 3'b111) $display("FAIL midop_opcode: got %b exp 111", alu_opcode); else n_pass++;
      n_chk++; if ({alu_a, alu_b} !== 32'd0) $display("FAIL midop_operands: got %h exp 0", {alu_a, alu_b}); else n_pass++;
      n_chk++; if ({carry_flag, illegal_op, timeout_err, busy} !== 4'b0000) $display("FAIL midop_flags: got %b exp 0000", {carry_flag, illegal_op, timeout_err, busy}); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), v);
         n_chk++; if (v !== 16'h0000) $display("FAIL midop_R%0d: got %h exp 0000", i, v); else n_pass++;
      end
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      ld_en       = 1'b0;
      ld_addr     = 3'd0;
      ld_data     = 16'h0000;
      dbg_addr    = 3'd0;
      alu_result  = 32'd0;
      alu_done    = 1'b0;
      test_reset();
      test_add();
      test_mul();
      test_sub();
      test_back_to_back();
      test_load_collisions();
      test_illegal();
      test_wait_limit();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
